// File: rtl/fdmas_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fdmas_pkg
//  Brief    : Shared types and width-derivation helpers for the streaming
//             F-DMAS beamformer (fdmas_stream_bf).
//  Revision : 1.0 - initial release
// ============================================================================
package fdmas_pkg;

    // Pixel framing state of the accumulator
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } fdmas_state_e;

    // Fixed latency of the pipelined square root
    function automatic int f_sqrt_lat(input int data_w);
        return data_w / 2;
    endfunction

    // Signed width of sign(x)*floor(sqrt(|x|))
    function automatic int f_sqrt_w(input int data_w);
        return data_w / 2 + 1;
    endfunction

    // Signed width that holds the pairwise product sum without overflow
    function automatic int f_out_w(input int sqrt_w, input int channels);
        return 2 * sqrt_w + 2 * $clog2(channels);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fdmas_stream_bf_if.sv
`default_nettype none
// ============================================================================
//  Module   : fdmas_stream_bf_if
//  Brief    : Sample stream in / pixel result out bundle of fdmas_stream_bf.
//             Carries das_out when FDMAS_DAS_OUT_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
interface fdmas_stream_bf_if
    import fdmas_pkg::*;
#(
    parameter int CHANNELS = 128,
    parameter int DATA_W   = 16,
    parameter int OUT_W    = f_out_w(f_sqrt_w(DATA_W), CHANNELS)
);
    logic                     in_valid;
    logic                     in_sof;
    logic signed [DATA_W-1:0] in_data;
    logic                     out_valid;
    logic signed [OUT_W-1:0]  out_data;
    logic                     frame_err;
`ifdef FDMAS_DAS_OUT_EN
    localparam int C_DAS_W = DATA_W + $clog2(CHANNELS);
    logic signed [C_DAS_W-1:0] das_out;

    modport slave  (input  in_valid, in_sof, in_data,
                    output out_valid, out_data, frame_err, das_out);
    modport master (output in_valid, in_sof, in_data,
                    input  out_valid, out_data, frame_err, das_out);
`else
    modport slave  (input  in_valid, in_sof, in_data,
                    output out_valid, out_data, frame_err);
    modport master (output in_valid, in_sof, in_data,
                    input  out_valid, out_data, frame_err);
`endif
endinterface
`default_nettype wire

// File: rtl/fdmas_isqrt.sv
`default_nettype none
// ============================================================================
//  Module   : fdmas_isqrt
//  Brief    : Pipelined non-restoring integer square root, one root bit per
//             stage, latency DATA_W/2 cycles, with valid and sideband carried
//             alongside. The pipeline never stalls.
//  Revision : 1.0 - initial release
// ============================================================================
module fdmas_isqrt #(
    parameter int DATA_W = 16,
    parameter int SB_W   = 1
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    input  wire logic                  in_valid,
    input  wire logic [DATA_W-1:0]     in_rad,
    input  wire logic [SB_W-1:0]       in_sb,
    output logic                       out_valid,
    output logic [DATA_W/2-1:0]        out_root,
    output logic [SB_W-1:0]            out_sb
);
    localparam int C_STAGES = DATA_W / 2;
    // Partial remainder stays within +/-2^(C_STAGES+1), so two guard bits suffice
    localparam int C_REM_W  = C_STAGES + 2;

    logic                r_vld [0:C_STAGES-1];
    logic [DATA_W-1:0]   r_rad [0:C_STAGES-1];
    logic [C_STAGES-1:0] r_q   [0:C_STAGES-1];
    logic [C_REM_W-1:0]  r_rem [0:C_STAGES-1];
    logic [SB_W-1:0]     r_sb  [0:C_STAGES-1];

    for (genvar k = 0; k < C_STAGES; k++) begin : g_stage
        logic                w_vld;
        logic [DATA_W-1:0]   w_rad;
        logic [C_STAGES-1:0] w_q;
        logic [C_REM_W-1:0]  w_rem;
        logic [SB_W-1:0]     w_sb;
        logic [C_REM_W-1:0]  w_shift;
        logic [C_REM_W-1:0]  w_trial;

        if (k == 0) begin : g_head
            assign w_vld = in_valid;
            assign w_rad = in_rad;
            assign w_q   = '0;
            assign w_rem = '0;
            assign w_sb  = in_sb;
        end else begin : g_link
            assign w_vld = r_vld[k-1];
            assign w_rad = r_rad[k-1];
            assign w_q   = r_q[k-1];
            assign w_rem = r_rem[k-1];
            assign w_sb  = r_sb[k-1];
        end

        // Bring down the next radicand bit pair; add or subtract depending on
        // the sign of the running remainder (no restore step needed)
        assign w_shift = C_REM_W'({w_rem, w_rad[DATA_W-1 -: 2]});
        assign w_trial = w_rem[C_REM_W-1] ? (w_shift + {w_q, 2'b11})
                                          : (w_shift - {w_q, 2'b01});

        // Register one stage: root bit is 1 when the new remainder is non-negative
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_vld[k] <= 1'b0;
                r_rad[k] <= '0;
                r_q[k]   <= '0;
                r_rem[k] <= '0;
                r_sb[k]  <= '0;
            end else begin
                r_vld[k] <= w_vld;
                r_rad[k] <= w_rad << 2;
                r_q[k]   <= {w_q[C_STAGES-2:0], ~w_trial[C_REM_W-1]};
                r_rem[k] <= w_trial;
                r_sb[k]  <= w_sb;
            end
        end
    end

    assign out_valid = r_vld[C_STAGES-1];
    assign out_root  = r_q[C_STAGES-1];
    assign out_sb    = r_sb[C_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/fdmas_stream_bf.sv
`default_nettype none
// ============================================================================
//  Module   : fdmas_stream_bf
//  Brief    : Streaming filtered delay-multiply-and-sum beamformer. Each
//             delayed channel sample is signed-square-rooted, then the pixel
//             result sum_{i<j} s_i*s_j is built as pair += s*sigma.
//             Optional macro FDMAS_DAS_OUT_EN adds das_out (plain DAS sum).
//  Revision : 1.0 - initial release
// ============================================================================
module fdmas_stream_bf
    import fdmas_pkg::*;
#(
    parameter int CHANNELS = 128,
    parameter int DATA_W   = 16,
    parameter int SQRT_W   = f_sqrt_w(DATA_W),
    parameter int OUT_W    = f_out_w(SQRT_W, CHANNELS)
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    fdmas_stream_bf_if.slave bus
);
    localparam int C_HALF  = f_sqrt_lat(DATA_W);
    localparam int C_CNT_W = $clog2(CHANNELS + 1);
    localparam logic [C_CNT_W-1:0] C_LAST = C_CNT_W'(CHANNELS - 1);
`ifdef FDMAS_DAS_OUT_EN
    localparam int C_DAS_W = DATA_W + $clog2(CHANNELS);
    localparam int C_SB_W  = 2 + DATA_W;
`else
    localparam int C_SB_W  = 2;
`endif

    // ---------------- sqrt front end ----------------
    logic                     w_neg;
    logic [DATA_W-1:0]        w_mag;
    logic [C_SB_W-1:0]        w_in_sb;
    logic                     w_sq_vld;
    logic [C_HALF-1:0]        w_root;
    logic [C_SB_W-1:0]        w_sq_sb;
    logic signed [SQRT_W-1:0] w_root_ext;

    // Two's-complement negate is exact for the most negative input when read unsigned
    assign w_neg   = bus.in_data[DATA_W-1];
    assign w_mag   = w_neg ? -bus.in_data : bus.in_data;
`ifdef FDMAS_DAS_OUT_EN
    assign w_in_sb = {bus.in_data, bus.in_sof, w_neg};
`else
    assign w_in_sb = {bus.in_sof, w_neg};
`endif

    fdmas_isqrt #(
        .DATA_W (DATA_W),
        .SB_W   (C_SB_W)
    ) u_isqrt (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (bus.in_valid),
        .in_rad    (w_mag),
        .in_sb     (w_in_sb),
        .out_valid (w_sq_vld),
        .out_root  (w_root),
        .out_sb    (w_sq_sb)
    );

    assign w_root_ext = SQRT_W'(w_root);

    // ---------------- signed sample stage ----------------
    logic                     r_s_vld;
    logic                     r_s_sof;
    logic signed [SQRT_W-1:0] r_s;

    // Re-apply the sign to the root; zero input already yields a zero root
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s_vld <= 1'b0;
            r_s_sof <= 1'b0;
            r_s     <= '0;
        end else begin
            r_s_vld <= w_sq_vld;
            r_s_sof <= w_sq_sb[1];
            r_s     <= w_sq_sb[0] ? -w_root_ext : w_root_ext;
        end
    end

    // ---------------- framing FSM and accumulators ----------------
    fdmas_state_e            r_state;
    fdmas_state_e            w_state;
    logic                    w_load;
    logic                    w_acc;
    logic                    w_done;
    logic                    w_err;
    logic signed [OUT_W-1:0] w_s_ext;
    logic signed [OUT_W-1:0] r_sigma;
    logic signed [OUT_W-1:0] r_pair;
    logic [C_CNT_W-1:0]      r_cnt;
    logic                    r_done;
    logic                    r_err;

    assign w_s_ext = OUT_W'(r_s);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state;
    end

    // Next state and per-sample actions; sof always restarts a pixel
    always_comb begin
        w_state = r_state;
        w_load  = 1'b0;
        w_acc   = 1'b0;
        w_done  = 1'b0;
        w_err   = 1'b0;
        if (r_s_vld) begin
            if (r_s_sof) begin
                w_load  = 1'b1;
                w_err   = (r_state == ST_ACC);
                w_state = ST_ACC;
            end else if (r_state == ST_ACC) begin
                w_acc = 1'b1;
                if (r_cnt == C_LAST) begin
                    w_done  = 1'b1;
                    w_state = ST_IDLE;
                end
            end else begin
                w_err = 1'b1;
            end
        end
    end

    // Running sum and pairwise sum; pair uses sigma before this sample is added
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sigma <= '0;
            r_pair  <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= w_done;
            r_err  <= w_err;
            if (w_load) begin
                r_sigma <= w_s_ext;
                r_pair  <= '0;
                r_cnt   <= C_CNT_W'(1);
            end else if (w_acc) begin
                r_sigma <= r_sigma + w_s_ext;
                r_pair  <= r_pair + w_s_ext * r_sigma;
                r_cnt   <= r_cnt + 1'b1;
            end
        end
    end

    // ---------------- output stage ----------------
    logic                    r_out_valid;
    logic signed [OUT_W-1:0] r_out_data;

    // Publish the completed pixel and hold it until the next one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_out_valid <= r_done;
            if (r_done) r_out_data <= r_pair;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.frame_err = r_err;

`ifdef FDMAS_DAS_OUT_EN
    logic signed [DATA_W-1:0]  r_s_raw;
    logic signed [C_DAS_W-1:0] r_das;
    logic signed [C_DAS_W-1:0] r_das_out;

    // Raw sample follows the sqrt pipeline so framing matches the DMAS path
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_s_raw <= '0;
        else        r_s_raw <= w_sq_sb[C_SB_W-1:2];
    end

    // Plain delay-and-sum over the pixel, published with out_valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_das     <= '0;
            r_das_out <= '0;
        end else begin
            if (w_load)     r_das <= C_DAS_W'(r_s_raw);
            else if (w_acc) r_das <= r_das + C_DAS_W'(r_s_raw);
            if (r_done)     r_das_out <= r_das;
        end
    end

    assign bus.das_out = r_das_out;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fdmas_stream_bf.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fdmas_stream_bf
//  Brief    : Self-checking bench for fdmas_stream_bf (CHANNELS=4, DATA_W=16).
//             Expected pixel values are queued as pixels are driven and
//             compared when out_valid pulses.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fdmas_stream_bf;
    import fdmas_pkg::*;

    localparam int CH  = 4;
    localparam int DW  = 16;
    localparam int LAT = f_sqrt_lat(DW);
    localparam int OW  = f_out_w(f_sqrt_w(DW), CH);

    typedef int pix_t [CH];

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    fdmas_stream_bf_if #(.CHANNELS(CH), .DATA_W(DW), .OUT_W(OW)) bus ();

    fdmas_stream_bf #(.CHANNELS(CH), .DATA_W(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int     checks   = 0;
    int     failures = 0;
    int     n_out    = 0;
    int     n_err    = 0;
    longint exp_q [$];
    longint das_q [$];

    // Output monitor: count pulses and score each completed pixel
    always @(negedge clk) begin
        longint got;
        longint e;
        if (rst_n) begin
            if (bus.frame_err === 1'b1) n_err++;
            if (bus.out_valid === 1'b1) begin
                n_out++;
                got = longint'($signed(bus.out_data));
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_out got=%0d required=no_output", got);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        failures++;
                        $display("FAIL out_data got=%0d required=%0d", got, e);
                    end
                end
`ifdef FDMAS_DAS_OUT_EN
                got = longint'($signed(bus.das_out));
                checks++;
                if (das_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_das got=%0d required=no_output", got);
                end else begin
                    e = das_q.pop_front();
                    if (got !== e) begin
                        failures++;
                        $display("FAIL das_out got=%0d required=%0d", got, e);
                    end
                end
`endif
            end
        end
    end

    // Reference model: sign(x)*floor(sqrt(|x|)) and sum over i<j of s_i*s_j
    function automatic int isq(input int v);
        int r = 0;
        while ((r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    function automatic int sgn_sqrt(input int x);
        return (x < 0) ? -isq(-x) : isq(x);
    endfunction

    function automatic longint dmas(input pix_t px);
        longint acc = 0;
        for (int i = 0; i < CH; i++)
            for (int j = i + 1; j < CH; j++)
                acc += longint'(sgn_sqrt(px[i])) * longint'(sgn_sqrt(px[j]));
        return acc;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int x, input bit sof);
        bus.in_valid = 1'b1;
        bus.in_sof   = sof;
        bus.in_data  = DW'(x);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
    endtask

    task automatic send_pixel(input pix_t px, input longint exp_v, input int max_gap);
        longint dsum = 0;
        for (int i = 0; i < CH; i++) dsum += px[i];
        exp_q.push_back(exp_v);
        das_q.push_back(dsum);
        for (int i = 0; i < CH; i++) begin
            if (max_gap > 0) idle($urandom_range(0, max_gap));
            send(px[i], i == 0);
        end
    endtask

    function automatic pix_t rand_pix();
        pix_t p;
        for (int i = 0; i < CH; i++) p[i] = int'($urandom_range(0, 65535)) - 32768;
        return p;
    endfunction

    // Bounded wait for the pipeline to empty; leftovers mean missing outputs
    task automatic drain();
        idle(LAT + 6);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_missing_out got=%0d required=0", exp_q.size());
        end
        exp_q.delete();
        das_q.delete();
    endtask

    task automatic check_counts(input string name, input int out0, input int d_out,
                                input int err0, input int d_err);
        checks++;
        if (n_out - out0 !== d_out) begin
            failures++;
            $display("FAIL %s_out_count got=%0d required=%0d", name, n_out - out0, d_out);
        end
        checks++;
        if (n_err - err0 !== d_err) begin
            failures++;
            $display("FAIL %s_frame_err_count got=%0d required=%0d", name, n_err - err0, d_err);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle(3);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_out_valid got=%b required=0", bus.out_valid);
        end
        checks++;
        if (bus.frame_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_frame_err got=%b required=0", bus.frame_err);
        end
        checks++;
        if (bus.out_data !== '0) begin
            failures++;
            $display("FAIL reset_out_data got=%0d required=0", $signed(bus.out_data));
        end
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_basic();
        pix_t p;
        int   lat = -1;
        int   o0 = n_out;
        int   e0 = n_err;
        p = '{4, 9, 16, 25};
        send_pixel(p, 71, 0);
        for (int k = 1; k <= LAT + 5; k++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid === 1'b1 && lat < 0) lat = k;
        end
        checks++;
        if (lat !== LAT + 2) begin
            failures++;
            $display("FAIL latency got=%0d required=%0d", lat, LAT + 2);
        end
        drain();
        check_counts("basic", o0, 1, e0, 0);
        checks++;
        if ($signed(bus.out_data) !== 71) begin
            failures++;
            $display("FAIL out_data_hold got=%0d required=71", $signed(bus.out_data));
        end
    endtask

    task automatic test_signs();
        pix_t p;
        int   o0 = n_out;
        int   e0 = n_err;
        p = '{-4, 9, -16, 25};
        send_pixel(p, -25, 0);
        p = '{-32768, -32768, 0, 10};
        send_pixel(p, 31675, 0);
        drain();
        check_counts("signs", o0, 2, e0, 0);
    endtask

    task automatic test_back_to_back();
        pix_t a;
        pix_t b;
        int   o0 = n_out;
        int   e0 = n_err;
        a = rand_pix();
        b = rand_pix();
        send_pixel(a, dmas(a), 0);
        send_pixel(b, dmas(b), 0);
        drain();
        send_pixel(a, dmas(a), 3);
        send_pixel(b, dmas(b), 3);
        drain();
        check_counts("b2b", o0, 4, e0, 0);
    endtask

    task automatic test_frame_err();
        pix_t p;
        int   o0 = n_out;
        int   e0 = n_err;
        send(100, 1'b1);
        send(200, 1'b0);
        send(300, 1'b0);
        p = rand_pix();
        send_pixel(p, dmas(p), 0);
        drain();
        check_counts("restart", o0, 1, e0, 1);
        o0 = n_out;
        e0 = n_err;
        send(49, 1'b0);
        drain();
        check_counts("idle_drop", o0, 0, e0, 1);
    endtask

    task automatic test_reset_mid();
        pix_t p;
        int   o0;
        int   e0;
        send(4, 1'b1);
        send(9, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_data !== '0 || bus.out_valid !== 1'b0 || bus.frame_err !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_outputs got=%0d/%b/%b required=0/0/0",
                     $signed(bus.out_data), bus.out_valid, bus.frame_err);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        o0 = n_out;
        e0 = n_err;
        idle(LAT + 4);
        check_counts("abandon", o0, 0, e0, 0);
        p = '{4, 9, 16, 25};
        send_pixel(p, 71, 0);
        drain();
        check_counts("after_reset", o0, 1, e0, 0);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_data  = '0;
        test_reset();
        test_basic();
        test_signs();
        test_back_to_back();
        test_frame_err();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fdmas_stream_bf.md
FDMAS_STREAM_BF -- requirements
Module: fdmas_stream_bf

Interface
REQ-001 Parameter CHANNELS, default 128: channel samples per pixel; legal range 2..1024.
REQ-002 Parameter DATA_W, default 16, even: signed width of delayed channel samples.
REQ-003 Parameter SQRT_W, default DATA_W/2+1: signed width of the signed-sqrt sample.
REQ-004 Parameter OUT_W, default 2*SQRT_W+2*$clog2(CHANNELS): signed width of the DMAS result.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 in_valid  input  1  in_data/in_sof are valid this cycle.
REQ-008 in_sof  input  1  qualifies the first channel sample of a pixel.
REQ-009 in_data  input  DATA_W signed  delayed channel sample.
REQ-010 out_valid  output  1  one-cycle pulse; out_data holds a completed pixel.
REQ-011 out_data  output  OUT_W signed  DMAS value of the pixel.
REQ-012 frame_err  output  1  one-cycle pulse on pixel framing error.

Function
REQ-013 The block SHALL accept one sample per in_valid cycle with no backpressure; gaps in in_valid SHALL stall only the counters and accumulators, never the sqrt pipeline.
REQ-014 Per sample the block SHALL form s = sign(x)*floor(sqrt(|x|)), with sign(0)=0 and |-2^(DATA_W-1)| handled exactly (16 bit: -32768 -> -181).
REQ-015 Sign, valid and sof SHALL be delayed alongside the sqrt pipeline of fixed latency SQRT_LAT = DATA_W/2 cycles.
REQ-016 Per pixel the block SHALL accumulate sigma += s and pair += s*sigma_prev (sigma before update), giving pair = sum over i<j of s_i*s_j.
REQ-017 A delayed sof sample SHALL load sigma = s and pair = 0, starting a new pixel with channel count 1.
REQ-018 All arithmetic SHALL be full-precision signed at OUT_W; no truncation or saturation.
REQ-019 When the channel count reaches CHANNELS, out_data SHALL take pair and out_valid SHALL pulse exactly SQRT_LAT+2 cycles after the edge that captured the last sample.
REQ-020 out_data SHALL hold its value until the next completed pixel.
REQ-021 States: IDLE (waiting for sof), ACC (count < CHANNELS); IDLE->ACC on delayed sof; ACC->IDLE when the pixel completes.
REQ-022 A sof in ACC SHALL pulse frame_err, discard the partial pixel without out_valid, and restart with that sample.
REQ-023 A non-sof valid sample in IDLE SHALL be dropped and SHALL pulse frame_err.
REQ-024 A sof arriving in the cycle immediately after a pixel's last sample SHALL start the next pixel with no lost cycle (back-to-back pixels).

Reset
REQ-025 Asserting rst_n low SHALL immediately clear out_valid, frame_err, out_data, the accumulators, the counters and all pipeline valid bits, and SHALL enter IDLE.
REQ-026 Reset mid-pixel SHALL abandon the pixel silently, with no out_valid and no frame_err.
REQ-027 The first sample accepted after rst_n deasserts SHALL be treated normally.

Configuration
REQ-028 Macro FDMAS_DAS_OUT_EN defined: the block SHALL add output das_out (signed, DATA_W+$clog2(CHANNELS)), the plain sum of raw in_data over the pixel, updated with out_valid and reset to 0.
REQ-029 Macro FDMAS_DAS_OUT_EN undefined: the port and its logic SHALL be absent and all other behaviour identical.

Structure
REQ-030 Package fdmas_pkg SHALL hold the state enum and the width-derivation functions for SQRT_W, OUT_W and SQRT_LAT.
REQ-031 Signed sqrt SHALL be sub-module fdmas_isqrt: a pipelined non-restoring integer sqrt with parameter DATA_W, latency DATA_W/2, and a valid and sideband passthrough.

Verification (CHANNELS=4, DATA_W=16)
REQ-032 sof+4,9,16,25 -> s=2,3,4,5; out_data=71, out_valid once, SQRT_LAT+2 cycles after the last sample.
REQ-033 sof+-4,9,-16,25 -> out_data=-25; sof+-32768,-32768,0,10 -> s=-181,-181,0,3, out_data=32761-1086=31675.
REQ-034 Two pixels back-to-back, then the same two pixels with random in_valid gaps -> identical outputs in both cases, no frame_err.
REQ-035 sof+2 samples, then sof+4 samples -> frame_err pulse, only the second pixel is output; a non-sof sample in IDLE -> dropped, frame_err.
REQ-036 rst_n low after 2 samples of a pixel -> outputs 0 immediately, no out_valid; the next full pixel is correct; with FDMAS_DAS_OUT_EN, 4,9,16,25 gives das_out=54.
